// File: rtl/mlaccel_sequencer_if.sv
// Signal bundle between the sequencer, its code memory and the compute unit.
// The abort line exists only when MLACCEL_SEQ_ABORT_EN is defined.
interface mlaccel_sequencer_if;
    logic        start;
    logic [15:0] start_addr;
    logic        busy;
    logic        done;
    logic        code_ren;
    logic [15:0] code_addr;
    logic [31:0] code_rdata;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_data;
    logic        compute_busy;
`ifdef MLACCEL_SEQ_ABORT_EN
    logic        abort;
`endif

    modport master (
        input  start, start_addr, code_rdata, cmd_ready, compute_busy,
`ifdef MLACCEL_SEQ_ABORT_EN
        input  abort,
`endif
        output busy, done, code_ren, code_addr, cmd_valid, cmd_data
    );

    modport slave (
        output start, start_addr, code_rdata, cmd_ready, compute_busy,
`ifdef MLACCEL_SEQ_ABORT_EN
        output abort,
`endif
        input  busy, done, code_ren, code_addr, cmd_valid, cmd_data
    );
endinterface

// File: rtl/mlaccel_sequencer.sv
// Fetches command words from code memory into a small FIFO for the compute unit
// until a halt opcode is read. Optional abort input: define MLACCEL_SEQ_ABORT_EN.
module mlaccel_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [3:0]  HALT_OP    = 4'hF
) (
    input  logic                clock,
    input  logic                resetn,
    mlaccel_sequencer_if.master sif
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_WAIT} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [15:0]      r_pc;
    logic [15:0]      r_last_addr;
    logic             r_inflight;
    logic [31:0]      r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_abort;
    logic             w_is_halt;
    logic             w_halt;
    logic             w_push;
    logic             w_pop;
    logic             w_room;
    logic             w_fifo_empty;
    logic             w_code_ren;
    logic             w_busy;
    logic             w_done;
    logic [CNT_W-1:0] w_occupancy;

`ifdef MLACCEL_SEQ_ABORT_EN
    // WAIT is already the abort destination, so only FETCH/DRAIN react.
    assign w_abort = sif.abort && ((r_state == S_FETCH) || (r_state == S_DRAIN));
`else
    assign w_abort = 1'b0;
`endif

    assign w_fifo_empty = (r_count == '0);
    assign w_is_halt    = r_inflight && (sif.code_rdata[31:28] == HALT_OP);
    assign w_halt       = (r_state == S_FETCH) && w_is_halt && !w_abort;
    assign w_push       = (r_state == S_FETCH) && r_inflight && !w_is_halt && !w_abort;
    assign w_pop        = !w_fifo_empty && sif.cmd_ready && !w_abort;
    // Reserving a slot for the read in flight means a push can never hit a full FIFO.
    assign w_occupancy  = r_count + CNT_W'(r_inflight);
    assign w_room       = (w_occupancy < CNT_W'(FIFO_DEPTH));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (sif.start)         w_state_next = S_FETCH;
            S_FETCH: if (w_halt)            w_state_next = S_DRAIN;
            S_DRAIN: if (w_fifo_empty)      w_state_next = S_WAIT;
            S_WAIT:  if (!sif.compute_busy) w_state_next = S_IDLE;
            default:                        w_state_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_state_next = S_WAIT;
        end
    end

    always_comb begin
        w_busy     = (r_state != S_IDLE);
        w_done     = (r_state == S_WAIT) && !sif.compute_busy;
        w_code_ren = (r_state == S_FETCH) && w_room && !w_is_halt && !w_abort;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pc        <= 16'h0000;
            r_last_addr <= 16'h0000;
            r_inflight  <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && sif.start) begin
                r_pc <= sif.start_addr;
            end else if (w_code_ren) begin
                r_pc <= r_pc + 16'd1;
            end
            if (w_code_ren) begin
                r_last_addr <= r_pc;
            end
            r_inflight <= w_code_ren;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= sif.code_rdata;
        end
    end

    assign sif.busy      = w_busy;
    assign sif.done      = w_done;
    assign sif.code_ren  = w_code_ren;
    assign sif.code_addr = w_code_ren ? r_pc : r_last_addr;
    assign sif.cmd_valid = !w_fifo_empty;
    assign sif.cmd_data  = w_fifo_empty ? 32'h0000_0000 : r_fifo_mem[r_rd_ptr];
endmodule
